// File: rtl/nabp_mapper_pkg.sv
// Shared types and defaults for the multi-channel projection mapper.
package nabp_mapper_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        MAPPING = 2'd2
    } map_state_e;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_LINE_SIZE    = 256;
    localparam int DEF_S_WIDTH      = 9;
    localparam int DEF_FRAC_WIDTH   = 8;
    localparam int DEF_ACCU_WIDTH   = 18;

    // Per-cycle commands broadcast from the shared FSM to every lane
    typedef struct packed {
        logic load;
        logic start;
        logic step;
        logic upd;
    } lane_ctrl_t;

    function automatic int range_limit(input int line_size, input int frac_width);
        return line_size << frac_width;
    endfunction

endpackage

// File: rtl/nabp_mapper_lane.sv
// One mapping channel: held seed/step, accumulator, range check and output register.
// NABP_MAPPER_CLAMP_EN selects saturation instead of zeroing for out-of-range addresses.
module nabp_mapper_lane
    import nabp_mapper_pkg::*;
#(
    parameter int LINE_SIZE  = DEF_LINE_SIZE,
    parameter int S_WIDTH    = DEF_S_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int ACCU_WIDTH = DEF_ACCU_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  lane_ctrl_t            ctrl,
    input  logic [ACCU_WIDTH-1:0] accu_init,
    input  logic [ACCU_WIDTH-1:0] accu_base,
    output logic [S_WIDTH-1:0]    s_val,
    output logic                  s_valid
);

    localparam logic signed [ACCU_WIDTH-1:0] LIMIT =
        ACCU_WIDTH'(range_limit(LINE_SIZE, FRAC_WIDTH));
    localparam logic [S_WIDTH-1:0] S_MAX = S_WIDTH'(LINE_SIZE - 1);

    logic signed [ACCU_WIDTH-1:0] init_q;
    logic signed [ACCU_WIDTH-1:0] base_q;
    logic signed [ACCU_WIDTH-1:0] accu;
    logic                         in_range;
    logic [S_WIDTH-1:0]           s_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q <= '0;
            base_q <= '0;
            accu   <= '0;
        end else begin
            if (ctrl.load) begin
                init_q <= accu_init;
                base_q <= accu_base;
            end
            // Wrapping two's-complement add; legal parameter sizing keeps it from wrapping
            if (ctrl.start)
                accu <= init_q;
            else if (ctrl.step)
                accu <= accu + base_q;
        end
    end

    always_comb begin
        in_range = !accu[ACCU_WIDTH-1] && (accu < LIMIT);
        s_next   = '0;
        if (in_range)
            s_next = accu[FRAC_WIDTH +: S_WIDTH];
`ifdef NABP_MAPPER_CLAMP_EN
        else if (!accu[ACCU_WIDTH-1])
            s_next = S_MAX;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_val   <= '0;
            s_valid <= 1'b0;
        end else if (ctrl.upd) begin
            s_val   <= s_next;
            s_valid <= in_range;
        end else begin
            s_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nabp_multi_mapper.sv
// Shared shifter-handshake FSM driving NUM_CHANNELS mapper lanes in lockstep.
// Build option NABP_MAPPER_CLAMP_EN is handled inside the lanes.
module nabp_multi_mapper
    import nabp_mapper_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int LINE_SIZE    = DEF_LINE_SIZE,
    parameter int S_WIDTH      = DEF_S_WIDTH,
    parameter int FRAC_WIDTH   = DEF_FRAC_WIDTH,
    parameter int ACCU_WIDTH   = DEF_ACCU_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               mp_load,
    input  logic [NUM_CHANNELS*ACCU_WIDTH-1:0] mp_accu_init,
    input  logic [NUM_CHANNELS*ACCU_WIDTH-1:0] mp_accu_base,
    input  logic                               sh_kick,
    input  logic                               sh_shift_enable,
    input  logic                               sh_done,
    output logic                               sh_ack,
    output logic                               mp_ready,
    output logic [NUM_CHANNELS*S_WIDTH-1:0]    rm_s_val,
    output logic [NUM_CHANNELS-1:0]            rm_s_valid
);

    map_state_e state;
    logic       accu_vld;
    lane_ctrl_t ctrl;

    // accu_vld marks accumulator contents belonging to a pass; it outlives MAPPING
    // by one cycle so a step taken together with sh_done still reaches the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sh_ack   <= 1'b0;
            mp_ready <= 1'b0;
            accu_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    accu_vld <= 1'b0;
                    if (mp_load) begin
                        state    <= READY;
                        mp_ready <= 1'b1;
                    end
                end
                READY: begin
                    accu_vld <= sh_kick && !mp_load;
                    if (!mp_load && sh_kick) begin
                        state    <= MAPPING;
                        sh_ack   <= 1'b1;
                        mp_ready <= 1'b0;
                    end
                end
                MAPPING: begin
                    accu_vld <= 1'b1;
                    if (sh_done) begin
                        state    <= READY;
                        sh_ack   <= 1'b0;
                        mp_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    sh_ack   <= 1'b0;
                    mp_ready <= 1'b0;
                    accu_vld <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ctrl       = '0;
        ctrl.load  = mp_load && (state != MAPPING);
        ctrl.start = (state == READY) && sh_kick && !mp_load;
        ctrl.step  = (state == MAPPING) && sh_shift_enable;
        ctrl.upd   = accu_vld;
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        nabp_mapper_lane #(
            .LINE_SIZE (LINE_SIZE),
            .S_WIDTH   (S_WIDTH),
            .FRAC_WIDTH(FRAC_WIDTH),
            .ACCU_WIDTH(ACCU_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .ctrl     (ctrl),
            .accu_init(mp_accu_init[i*ACCU_WIDTH +: ACCU_WIDTH]),
            .accu_base(mp_accu_base[i*ACCU_WIDTH +: ACCU_WIDTH]),
            .s_val    (rm_s_val[i*S_WIDTH +: S_WIDTH]),
            .s_valid  (rm_s_valid[i])
        );
    end

endmodule
